// File: rtl/ex_pkg.sv
// Shared definitions for the EX result stage: branch condition codes and
// the buffered result record handed to the MEM stage.
package ex_pkg;

  // Datapath width of the buffered result record.
  localparam int EX_XLEN = 32;

  // Branch condition codes carried in funct3.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // One skid-buffer entry as seen by the MEM stage.
  typedef struct packed {
    logic [EX_XLEN-1:0] result;
    logic [4:0]         rd;
    logic               reg_write;
  } ex_result_t;

endpackage

// File: rtl/ex_branch_resolve.sv
// Combinational branch/jump resolution: decides whether the instruction
// redirects fetch and computes the redirect target.
// Priority when several kinds are flagged: jalr > jal > branch.
module ex_branch_resolve #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            zero,
  input  logic            less_than,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_out,
  output logic            taken,
  output logic [XLEN-1:0] target
);
  import ex_pkg::*;

  // Taken decision and target; pc + imm wraps naturally at XLEN bits.
  always_comb begin
    taken  = 1'b0;
    target = pc + imm;
    if (is_jalr) begin
      taken  = 1'b1;
      target = {alu_out[XLEN-1:1], 1'b0};
    end else if (is_jal) begin
      taken  = 1'b1;
    end else if (is_branch) begin
      case (funct3)
        F3_BEQ:           taken = zero;
        F3_BNE:           taken = ~zero;
        F3_BLT, F3_BLTU:  taken = less_than;
        F3_BGE, F3_BGEU:  taken = ~less_than;
        default:          taken = 1'b0;
      endcase
    end else begin
      taken = 1'b0;
    end
  end

endmodule

// File: rtl/ex_result_stage.sv
// EX result stage: 2-entry skid buffer between the ALU and the EX/MEM
// boundary, with registered branch/jump redirect to fetch.
// Optional macro EX_FWD_EN adds fwd_valid/fwd_rd/fwd_data, mirroring the
// youngest buffered entry that writes a non-zero rd.
// XLEN must match ex_pkg::EX_XLEN (width of the buffered record).
module ex_result_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_out,
  input  logic            zero,
  input  logic            less_than,
  input  logic [2:0]      funct3,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
`ifdef EX_FWD_EN
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);
  import ex_pkg::*;

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [1:0]      count_q, count_d;
  logic            in_ready_q, in_ready_d;
  ex_result_t      ent0_q, ent0_d, ent1_q, ent1_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            taken_s;
  logic [XLEN-1:0] target_s;
  logic            jump_s, br_s, push_s, pop_s;
  ex_result_t      new_ent_s;

  ex_branch_resolve #(.XLEN(XLEN)) u_resolve (
    .funct3    (funct3),
    .zero      (zero),
    .less_than (less_than),
    .is_branch (is_branch),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr),
    .pc        (pc),
    .imm       (imm),
    .alu_out   (alu_out),
    .taken     (taken_s),
    .target    (target_s)
  );

  assign out_valid = (count_q != 2'd0);

  // Build the incoming entry; a jump outranks a simultaneous branch flag.
  always_comb begin
    new_ent_s           = '0;
    jump_s              = is_jal | is_jalr;
    br_s                = is_branch & ~jump_s;
    new_ent_s.result    = jump_s ? (pc + {{(XLEN-3){1'b0}}, 3'd4}) : alu_out;
    new_ent_s.rd        = rd;
    new_ent_s.reg_write = reg_write & ~br_s & (rd != 5'd0);
    push_s              = in_valid & in_ready_q & ~flush;
    pop_s               = out_valid & out_ready;
  end

  // Skid buffer: head in ent0, younger entry in ent1; flush empties it.
  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case (count_q)
      2'd0: begin
        if (push_s) begin
          ent0_d  = new_ent_s;
          count_d = 2'd1;
        end else begin
          count_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          ent0_d  = new_ent_s;
        end else if (push_s) begin
          ent1_d  = new_ent_s;
          count_d = 2'd2;
        end else if (pop_s) begin
          count_d = 2'd0;
        end else begin
          count_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          ent0_d  = ent1_q;
          count_d = 2'd1;
        end else begin
          count_d = 2'd2;
        end
      end
      default: count_d = 2'd0;
    endcase
    if (flush) begin
      count_d = 2'd0;
    end else begin
      count_d = count_d;
    end
    in_ready_d = (count_d < DEPTH_C);
  end

  // Redirect pulses only for an accepted taken instruction; target is held otherwise.
  always_comb begin
    redirect_valid_d = push_s & taken_s;
    if (push_s && taken_s) begin
      redirect_pc_d = target_s;
    end else begin
      redirect_pc_d = redirect_pc_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q          <= 2'd0;
      in_ready_q       <= 1'b1;
      ent0_q           <= '0;
      ent1_q           <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      count_q          <= count_d;
      in_ready_q       <= in_ready_d;
      ent0_q           <= ent0_d;
      ent1_q           <= ent1_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_result     = ent0_q.result;
  assign out_rd         = ent0_q.rd;
  assign out_reg_write  = ent0_q.reg_write;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef EX_FWD_EN
  // Forward the youngest buffered entry that writes a register.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = 5'd0;
    fwd_data  = '0;
    if (count_q == 2'd2 && ent1_q.reg_write) begin
      fwd_valid = 1'b1;
      fwd_rd    = ent1_q.rd;
      fwd_data  = ent1_q.result;
    end else if (count_q != 2'd0 && ent0_q.reg_write) begin
      fwd_valid = 1'b1;
      fwd_rd    = ent0_q.rd;
      fwd_data  = ent0_q.result;
    end else begin
      fwd_valid = 1'b0;
    end
  end
`endif

endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- Receiving end of the EX-stage ALU outputs (alu_out, zero, less_than). Captures each result into a 2-entry skid buffer and resolves branch and jump decisions from the flags.
- Issues a registered redirect pulse to fetch.
- Hands results to the MEM stage over a valid/ready handshake. Sits between the ALU and the EX/MEM boundary.

Parameters:
- XLEN, 32, datapath and PC width
- DEPTH, 2, skid buffer entries; fixed at 2, other values unsupported

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  stage can accept; registered, high when count < 2
- alu_out  in  XLEN  ALU result
- zero  in  1  ALU zero flag
- less_than  in  1  ALU compare flag (signed or unsigned already selected)
- funct3  in  3  branch condition code
- is_branch  in  1  conditional branch
- is_jal  in  1  JAL
- is_jalr  in  1  JALR
- pc  in  XLEN  instruction PC
- imm  in  XLEN  sign-extended immediate
- rd  in  5  destination register
- reg_write  in  1  writes rd
- flush  in  1  discard buffered and incoming entries
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM accepts head
- out_result  out  XLEN  writeback value
- out_rd  out  5  destination
- out_reg_write  out  1  write enable; forced 0 when rd == 0
- redirect_valid  out  1  one-cycle pulse, taken branch or jump
- redirect_pc  out  XLEN  target

Behaviour:
- Reset (async, rst_n low): count = 0, out_valid = 0, in_ready = 1, redirect_valid = 0, redirect_pc = 0, out_result = 0, out_rd = 0, out_reg_write = 0.
- Push: on in_valid && in_ready. Pop: on out_valid && out_ready. Push and pop together when count = 1 leaves count = 1 and keeps FIFO order. count = 2 forces in_ready low, so no push.
- Latency: an accepted entry appears on out_* the next cycle when the buffer was empty.
- Result:
  - is_jal or is_jalr: result = pc + 4.
  - is_branch: result = alu_out, reg_write forced 0.
  - Otherwise: result = alu_out.
- Taken rules for branches, by funct3:
  - 000: taken if zero
  - 001: taken if !zero
  - 100 or 110: taken if less_than
  - 101 or 111: taken if !less_than
  - 010 or 011: never taken
- Jumps are always taken.
- Target:
  - JALR: alu_out with bit 0 cleared.
  - Branch and JAL: pc + imm, wrapping modulo 2^XLEN.
- Redirect: redirect_valid is asserted the cycle after a push of a taken instruction, with redirect_pc registered at the same time. It is never asserted for a dropped input.
- Flush: takes priority over everything. In the same cycle the incoming beat is dropped and redirect is suppressed. Next cycle count = 0, out_valid = 0, in_ready = 1. A redirect already in flight (pulse this cycle) is not cancelled.
- If pop and flush occur together, the pop still completes at the MEM stage and the buffer clears.
- out_* holds stable while out_valid && !out_ready.
- Reset mid-operation: the buffer is emptied immediately and the pending redirect is lost.
- If is_jal, is_jalr and is_branch are all set at once, priority is jalr > jal > branch.

Optional Feature:
- Macro: EX_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_rd (5) and fwd_data (XLEN). These mirror the youngest valid buffer entry with reg_write && rd != 0, combinationally, for the operand-forwarding mux. fwd_valid = 0 when empty or after flush.
- Undefined: these ports are absent and no forwarding logic is built.

Decomposition:
- Shared package ex_pkg:
  - Branch funct3 localparams (F3_BEQ .. F3_BGEU).
  - A packed struct ex_result_t {result, rd, reg_write}.
- One sub-module: ex_branch_resolve, combinational. Takes funct3, the flags, the jump kinds, pc, imm and alu_out; returns taken and target.
- The skid buffer lives in the top module.

Test Plan:
- BEQ, zero = 1, pc = 0x100, imm = 0x20 -> next cycle redirect_valid = 1, redirect_pc = 0x120, out_reg_write = 0. BNE with zero = 1 -> no redirect.
- JALR, alu_out = 0x2003, pc = 0x40, rd = 1 -> redirect_pc = 0x2002, out_result = 0x44, out_reg_write = 1.
- Hold out_ready = 0 and push 3 beats -> in_ready low after 2. Release -> beats pop in order A, B, and C is accepted only after in_ready returns.
- count = 2, flush with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, no redirect for the dropped beat.
- ADD with rd = 0, reg_write = 1 -> out_reg_write = 0. BLTU with less_than = 1, pc = 0xFFFFFFF0, imm = 0x20 -> redirect_pc = 0x10 (wrap).
- Assert rst_n = 0 while count = 1 and a redirect is pending -> outputs drop to reset values asynchronously. With EX_FWD_EN defined -> fwd_valid = 0.
